// File: rtl/score_keeper.sv
// score_keeper: match-state controller feeding the two-digit score display.
// Counts points for both players, detects the winning score and sequences
// serves back to the ball logic. All outputs come straight from registers.
//
// Optional build macro SCORE_AUTO_RESTART_EN: when defined, GAME_OVER ends on
// its own after GAMEOVER_CYCLES clocks (a start press still restarts sooner).
// When undefined, no game-over timer exists and GAME_OVER is left only by a
// start press or reset.
module score_keeper #(
    parameter int WIN_SCORE       = 9,
    parameter int HOLDOFF_CYCLES  = 2048,
    parameter int GAMEOVER_CYCLES = 8192
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       serve,
    output logic       serve_dir,
    output logic       in_play,
    output logic       game_over
);

    localparam int                HOLD_W    = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);
    // A point scored at this value is the winning point.
    localparam logic [3:0]        WIN_M1    = 4'(WIN_SCORE - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SERVE     = 2'd1;
    localparam logic [1:0] ST_PLAY      = 2'd2;
    localparam logic [1:0] ST_GAME_OVER = 2'd3;

    // Out-of-range parameters leave this marker block in the elaborated
    // hierarchy so a bad configuration is easy to spot.
    if (WIN_SCORE < 1 || WIN_SCORE > 15 || HOLDOFF_CYCLES < 1 || GAMEOVER_CYCLES < 1) begin : g_param_out_of_range
    end

    logic [1:0]        state_reg,     state_next;
    logic [HOLD_W-1:0] hold_cnt_reg,  hold_cnt_next;
    logic [3:0]        score_p1_reg,  score_p1_next;
    logic [3:0]        score_p2_reg,  score_p2_next;
    logic              serve_reg,     serve_next;
    logic              serve_dir_reg, serve_dir_next;
    logic              in_play_reg;
    logic              game_over_reg;
    logic              start_q_reg;
    logic              start_rise;
    logic              restart_req;

    assign start_rise = start & ~start_q_reg;

`ifdef SCORE_AUTO_RESTART_EN
    localparam int              GO_W    = $clog2(GAMEOVER_CYCLES + 1);
    localparam logic [GO_W-1:0] GO_LOAD = GO_W'(GAMEOVER_CYCLES - 1);

    logic [GO_W-1:0] go_cnt_reg, go_cnt_next;

    // Game-over timer expiring acts exactly like a start press.
    assign restart_req = start_rise | (go_cnt_reg == '0);

    // Game-over timer: load on entry to GAME_OVER, count down while there.
    always_comb begin
        go_cnt_next = go_cnt_reg;
        if (state_reg != ST_GAME_OVER && state_next == ST_GAME_OVER) begin
            go_cnt_next = GO_LOAD;
        end else if (state_reg == ST_GAME_OVER && go_cnt_reg != '0) begin
            go_cnt_next = go_cnt_reg - GO_W'(1);
        end
    end

    // Game-over timer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            go_cnt_reg <= '0;
        end else begin
            go_cnt_reg <= go_cnt_next;
        end
    end
`else
    assign restart_req = start_rise;
`endif

    // Match sequencing: next state, scores, holdoff counter and serve strobe.
    always_comb begin
        state_next     = state_reg;
        hold_cnt_next  = hold_cnt_reg;
        score_p1_next  = score_p1_reg;
        score_p2_next  = score_p2_reg;
        serve_next     = 1'b0;
        serve_dir_next = serve_dir_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_rise) begin
                    score_p1_next = 4'd0;
                    score_p2_next = 4'd0;
                    hold_cnt_next = HOLD_LOAD;
                    state_next    = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (hold_cnt_reg == '0) begin
                    serve_next = 1'b1;
                    state_next = ST_PLAY;
                end else begin
                    hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
                end
            end
            ST_PLAY: begin
                if (point_p1 && point_p2) begin
                    // Simultaneous points void the rally; just re-serve.
                    hold_cnt_next = HOLD_LOAD;
                    state_next    = ST_SERVE;
                end else if (point_p1) begin
                    score_p1_next  = score_p1_reg + 4'd1;
                    serve_dir_next = 1'b1;
                    if (score_p1_reg == WIN_M1) begin
                        state_next = ST_GAME_OVER;
                    end else begin
                        hold_cnt_next = HOLD_LOAD;
                        state_next    = ST_SERVE;
                    end
                end else if (point_p2) begin
                    score_p2_next  = score_p2_reg + 4'd1;
                    serve_dir_next = 1'b0;
                    if (score_p2_reg == WIN_M1) begin
                        state_next = ST_GAME_OVER;
                    end else begin
                        hold_cnt_next = HOLD_LOAD;
                        state_next    = ST_SERVE;
                    end
                end
            end
            default: begin
                // GAME_OVER: scores frozen until a restart.
                if (restart_req) begin
                    score_p1_next = 4'd0;
                    score_p2_next = 4'd0;
                    hold_cnt_next = HOLD_LOAD;
                    state_next    = ST_SERVE;
                end
            end
        endcase
    end

    // State and output registers; status flags decode the next state so they
    // line up with the state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            hold_cnt_reg  <= '0;
            score_p1_reg  <= 4'd0;
            score_p2_reg  <= 4'd0;
            serve_reg     <= 1'b0;
            serve_dir_reg <= 1'b0;
            in_play_reg   <= 1'b0;
            game_over_reg <= 1'b0;
            start_q_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            score_p1_reg  <= score_p1_next;
            score_p2_reg  <= score_p2_next;
            serve_reg     <= serve_next;
            serve_dir_reg <= serve_dir_next;
            in_play_reg   <= (state_next == ST_PLAY);
            game_over_reg <= (state_next == ST_GAME_OVER);
            start_q_reg   <= start;
        end
    end

    assign score_p1  = score_p1_reg;
    assign score_p2  = score_p2_reg;
    assign serve     = serve_reg;
    assign serve_dir = serve_dir_reg;
    assign in_play   = in_play_reg;
    assign game_over = game_over_reg;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized bench for score_keeper against an event-level
// reference model (serve deadlines kept as absolute cycle numbers).
// Honours SCORE_AUTO_RESTART_EN the same way the design does.
module tb_score_keeper;

    localparam int WIN  = 9;
    localparam int HOLD = 4;
    localparam int GOC  = 8;

`ifdef SCORE_AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_SERVE = 2'd1;
    localparam logic [1:0] M_PLAY  = 2'd2;
    localparam logic [1:0] M_OVER  = 2'd3;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       start    = 1'b0;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       serve;
    logic       serve_dir;
    logic       in_play;
    logic       game_over;

    score_keeper #(
        .WIN_SCORE      (WIN),
        .HOLDOFF_CYCLES (HOLD),
        .GAMEOVER_CYCLES(GOC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .point_p1 (point_p1),
        .point_p2 (point_p2),
        .score_p1 (score_p1),
        .score_p2 (score_p2),
        .serve    (serve),
        .serve_dir(serve_dir),
        .in_play  (in_play),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        int         serve_at;   // clock edge at which the strobe is due
        int         over_end;   // clock edge at which auto-restart fires
        logic [1:0] mode;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       dir;
        logic       srv;
        logic       sp;         // start level seen at the previous edge
    } mdl_t;

    mdl_t m = '0;

    // One clock edge of the reference model, edge number n.
    function automatic mdl_t step(input mdl_t cur, input int n,
                                  input logic st, input logic a, input logic b);
        mdl_t r;
        logic rise;
        r     = cur;
        rise  = st & ~cur.sp;
        r.sp  = st;
        r.srv = 1'b0;
        if (cur.mode == M_IDLE || cur.mode == M_OVER) begin
            if (rise || (AUTO && cur.mode == M_OVER && n == cur.over_end)) begin
                r.s1 = 4'd0;
                r.s2 = 4'd0;
                r.mode = M_SERVE;
                r.serve_at = n + HOLD;
            end
        end else if (cur.mode == M_SERVE) begin
            if (n == cur.serve_at) begin
                r.srv = 1'b1;
                r.mode = M_PLAY;
            end
        end else begin
            if (a && b) begin
                r.mode = M_SERVE;
                r.serve_at = n + HOLD;
            end else if (a || b) begin
                if (a) begin
                    r.s1 = cur.s1 + 4'd1;
                    r.dir = 1'b1;
                end else begin
                    r.s2 = cur.s2 + 4'd1;
                    r.dir = 1'b0;
                end
                if (int'(r.s1) == WIN || int'(r.s2) == WIN) begin
                    r.mode = M_OVER;
                    r.over_end = n + GOC;
                end else begin
                    r.mode = M_SERVE;
                    r.serve_at = n + HOLD;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else          m <= step(m, cyc, start, point_p1, point_p2);
    end

    function automatic logic [31:0] dut_outs();
        return {20'd0, score_p1, score_p2, serve, serve_dir, in_play, game_over};
    endfunction

    function automatic logic [31:0] exp_outs();
        return {20'd0, m.s1, m.s2, m.srv, m.dir, m.mode == M_PLAY, m.mode == M_OVER};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, obs, expv, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output to the model.
    task automatic tick();
        @(negedge clk);
        chk("outs", dut_outs(), exp_outs());
    endtask

    // Wait for PLAY, poking ignored inputs at random while serving.
    task automatic wait_play();
        int k;
        k = 0;
        while (in_play !== 1'b1 && k < 200) begin
            if (m.mode == M_SERVE) begin
                point_p1 = ($urandom_range(0, 3) == 0);
                point_p2 = ($urandom_range(0, 3) == 0);
                start    = 1'($urandom_range(0, 1));
            end
            tick();
            k++;
        end
        point_p1 = 1'b0;
        point_p2 = 1'b0;
        start    = 1'b0;
        chk("wait_play", in_play, 1);
    endtask

    // which: 1 = p1, 2 = p2, 3 = both (void rally).
    task automatic give_point(input int which);
        int k;
        wait_play();
        repeat ($urandom_range(0, 3)) tick();
        point_p1 = which[0];
        point_p2 = which[1];
        k = 0;
        do begin
            tick();
            k++;
            point_p1 = 1'b0;
            point_p2 = 1'b0;
        end while (serve !== 1'b1 && game_over !== 1'b1 && k < 50);
        if (game_over === 1'b1) chk("go_entry_lat", k, 1);
        else                    chk("reserve_lat", k, HOLD + 1);
        $display("point %0d -> score %0d/%0d dir=%0d over=%0d", which, score_p1, score_p2, serve_dir, game_over);
    endtask

    initial begin
        int k;
        int nserve;

        // Reset state.
        repeat (3) tick();
        chk("rst_outs", dut_outs(), 0);
        reset_n = 1'b1;
        tick();

        // First serve: one edge to see the rise, then HOLD edges in SERVE.
        start = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
            start = 1'b0;
        end while (serve !== 1'b1 && k < 50);
        chk("first_serve_lat", k, HOLD + 1);
        chk("first_dir", serve_dir, 0);
        chk("first_scores", {score_p1, score_p2}, 0);
        tick();
        chk("in_play_after_serve", in_play, 1);
        $display("serve #1 after %0d cycles", k);

        // Game 1: reach 2/2, void a rally, then random play to the end.
        give_point(1);
        give_point(2);
        give_point(1);
        give_point(2);
        chk("g1_2_2", {score_p1, score_p2}, 8'h22);
        give_point(3);
        chk("void_scores", {score_p1, score_p2}, 8'h22);
        chk("void_dir", serve_dir, 0);
        k = 0;
        while (game_over !== 1'b1 && k < 60) begin
            give_point(int'($urandom_range(1, 3)));
            k++;
        end
        chk("g1_over", game_over, 1);
        chk("g1_win", (score_p1 == 4'(WIN)) || (score_p2 == 4'(WIN)), 1);

        // Game 2: start press out of GAME_OVER, then 3/1 and p1 wins.
        start = 1'b1;
        tick();
        start = 1'b0;
        give_point(1);
        chk("g2_first", {score_p1, score_p2}, 8'h10);
        chk("dir_after_p1", serve_dir, 1);
        give_point(1);
        give_point(1);
        give_point(2);
        chk("g2_3_1", {score_p1, score_p2}, 8'h31);
        chk("dir_after_p2", serve_dir, 0);
        repeat (WIN - 3) give_point(1);
        chk("g2_over", game_over, 1);
        chk("g2_in_play", in_play, 0);
        chk("g2_p1_win", score_p1, WIN);

`ifdef SCORE_AUTO_RESTART_EN
        k = 1;
        while (game_over === 1'b1 && k < 50) begin
            point_p1 = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        point_p1 = 1'b0;
        chk("go_len", k, GOC + 1);
        chk("auto_clear", {score_p1, score_p2}, 0);
`else
        repeat (3) begin
            point_p1 = 1'b1;
            point_p2 = 1'($urandom_range(0, 1));
            tick();
        end
        point_p1 = 1'b0;
        point_p2 = 1'b0;
        repeat (1000) tick();
        chk("go_hold", game_over, 1);
        chk("go_score", {score_p1, score_p2}, {4'(WIN), 4'd1});
        start = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
            start = 1'b0;
        end while (serve !== 1'b1 && k < 50);
        chk("restart_lat", k, HOLD + 1);
        chk("restart_clear", {score_p1, score_p2}, 0);
`endif

        // Async reset in SERVE with the holdoff counter at 2.
        wait_play();
        point_p1 = 1'b1;
        point_p2 = 1'b1;
        tick();
        point_p1 = 1'b0;
        point_p2 = 1'b0;
        k = 0;
        while (!(m.mode == M_SERVE && m.serve_at - cyc == 2) && k < 20) begin
            tick();
            k++;
        end
        chk("rst_setup", k < 20, 1);
        #3 reset_n = 1'b0;
        #1 chk("async_rst", dut_outs(), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        nserve = 0;
        repeat (30) begin
            tick();
            if (serve === 1'b1) nserve++;
        end
        chk("no_serve_after_rst", nserve, 0);
        chk("idle_after_rst", {in_play, game_over}, 0);
        $display("reset mid-serve, %0d serves after release", nserve);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Match-state controller directly upstream of the two-digit score display.
- Counts points for both players, detects the winning score and sequences serves.
- Drives the two 4-bit score buses that the display renders, and blinks once either score reaches 9.
- Consumes point pulses from the ball/collision logic and a start button; emits a serve strobe and direction back to the ball logic.

Parameters:
- WIN_SCORE, 9, score that ends the match; legal range 1..15. Default matches the display's game-over blink threshold.
- HOLDOFF_CYCLES, 2048, clk cycles of pause between entering SERVE and the serve strobe; must be >= 1.
- GAMEOVER_CYCLES, 8192, clk cycles spent in GAME_OVER before auto-restart. Used only with SCORE_AUTO_RESTART_EN.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- start  input  1  start button, synchronous, level. Only its rising edge is used.
- point_p1  input  1  one-cycle pulse: player 1 scored.
- point_p2  input  1  one-cycle pulse: player 2 scored.
- score_p1  output  4  player 1 score, registered.
- score_p2  output  4  player 2 score, registered.
- serve  output  1  one-cycle strobe: launch ball now.
- serve_dir  output  1  ball direction for the serve: 0 = toward p1, 1 = toward p2.
- in_play  output  1  high while state is PLAY.
- game_over  output  1  high while state is GAME_OVER.

Behaviour:
- Reset (reset_n low, async): state IDLE; score_p1/score_p2 = 0; serve = 0; serve_dir = 0; in_play = 0; game_over = 0; holdoff counter = 0; start edge register = 0. Deassertion takes effect on the next clk edge.
- Start edge detection: start_q registered each cycle; start_rise = start & ~start_q. Detection has 1-cycle latency from the input.
- States are IDLE, SERVE, PLAY and GAME_OVER.
- IDLE:
  - start_rise -> clear both scores, load holdoff counter = HOLDOFF_CYCLES-1, go to SERVE.
  - serve_dir is left unchanged, so the first serve goes toward p1.
- SERVE:
  - Counter decrements each cycle.
  - In the cycle the counter is 0: serve = 1 for exactly one cycle, next state PLAY.
  - Serve-to-strobe latency is exactly HOLDOFF_CYCLES cycles after entering SERVE.
- PLAY (in_play = 1):
  - point_p1 only: score_p1 += 1; serve_dir <= 1, so the next ball goes toward p2, the point winner's opponent.
  - point_p2 only: score_p2 += 1; serve_dir <= 0.
  - After an increment: if the new score == WIN_SCORE go to GAME_OVER; otherwise reload the counter and go to SERVE.
  - point_p1 and point_p2 in the same cycle: rally void. No score change, serve_dir unchanged, reload counter, go to SERVE.
  - Scores update on the same edge as the state change; outputs are registered, no combinational path from point_* to outputs.
- GAME_OVER (game_over = 1):
  - Scores are held.
  - start_rise -> clear scores, load counter, go to SERVE (the serve strobe follows HOLDOFF_CYCLES later).
- Inputs ignored by state:
  - point_p1/point_p2 are ignored outside PLAY.
  - start is ignored in SERVE and PLAY.
- Scores never exceed WIN_SCORE; no wrap-around is possible.
- Holdoff counter width is $clog2(HOLDOFF_CYCLES+1).
- Reset mid-match (any state) returns immediately to the reset values above. A pending serve strobe is cancelled.

Optional Feature:
- Macro SCORE_AUTO_RESTART_EN.
- Defined:
  - On entry to GAME_OVER a counter loads GAMEOVER_CYCLES-1 and decrements.
  - At 0 the block behaves as if start_rise occurred: scores clear and it goes to SERVE.
  - A real start_rise earlier restarts immediately.
- Undefined: no counter is instantiated; GAME_OVER is left only via start_rise or reset.

Test Plan:
- Reset then start pulse, with HOLDOFF_CYCLES=4 -> start_rise seen 1 cycle after start; serve high exactly 4 cycles after entering SERVE, for 1 cycle; serve_dir=0; in_play=1 the next cycle; scores 0/0.
- In PLAY, pulse point_p1 three times and point_p2 once, each after its serve -> scores 3/1. serve_dir follows the last point: 1 after each p1 point, 0 after the p2 point. Each point produces SERVE and a serve strobe 4 cycles later.
- point_p1 and point_p2 in the same cycle at 2/2 -> scores stay 2/2; serve_dir unchanged; re-serve after 4 cycles.
- p1 reaches 9 (WIN_SCORE=9) -> game_over=1, in_play=0, score_p1=9 held. Extra point pulses and 100 idle cycles cause no change. start_rise -> scores 0/0, then a serve strobe.
- Assert reset_n low asynchronously (not clock-aligned) in SERVE with counter=2 -> outputs go to reset values immediately; no serve strobe after release.
- With SCORE_AUTO_RESTART_EN and GAMEOVER_CYCLES=8 -> GAME_OVER lasts exactly 8 cycles, then scores clear and SERVE is entered. Without the macro, the block stays in GAME_OVER for 1000 cycles.
